// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch and data ports onto a single physical memory port.
// One transaction in flight; dmem has priority, bounded by STARVE_LIMIT.
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [31:0] imem_address,
    input  logic        imem_read,
    output logic [31:0] imem_rdata,
    output logic        imem_resp,

    input  logic [31:0] dmem_address,
    input  logic        dmem_read,
    input  logic        dmem_write,
    input  logic [3:0]  dmem_wmask,
    input  logic [31:0] dmem_wdata,
    output logic [31:0] dmem_rdata,
    output logic        dmem_resp,

    output logic [31:0] pmem_address,
    output logic        pmem_read,
    output logic        pmem_write,
    output logic [3:0]  pmem_wmask,
    output logic [31:0] pmem_wdata,
    input  logic [31:0] pmem_rdata,
    input  logic        pmem_resp
);

    localparam int unsigned SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    typedef enum logic [1:0] {IDLE, IBUSY, DBUSY, RESP} state_t;

    state_t        state, state_next;
    logic [SW-1:0] dstreak;
    logic          dmem_req;
    logic          starved;
    logic          grant_i, grant_d;
    logic          serve_d;

    always_comb begin
        dmem_req   = dmem_read | dmem_write;
        starved    = (dstreak == SW'(STARVE_LIMIT));
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        state_next = state;
        case (state)
            IDLE: begin
                if (imem_read && (!dmem_req || starved)) begin
                    grant_i    = 1'b1;
                    state_next = IBUSY;
                end else if (dmem_req) begin
                    grant_d    = 1'b1;
                    state_next = DBUSY;
                end
            end
            IBUSY, DBUSY: if (pmem_resp) state_next = RESP;
            RESP:         state_next = IDLE;
            default:      state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dstreak      <= '0;
            serve_d      <= 1'b0;
            pmem_address <= '0;
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            pmem_wmask   <= '0;
            pmem_wdata   <= '0;
            imem_rdata   <= '0;
            dmem_rdata   <= '0;
            imem_resp    <= 1'b0;
            dmem_resp    <= 1'b0;
        end else begin
            imem_resp <= 1'b0;
            dmem_resp <= 1'b0;
            if (grant_i) begin
                serve_d      <= 1'b0;
                dstreak      <= '0;
                pmem_address <= {imem_address[31:2], 2'b00};
                pmem_read    <= 1'b1;
                pmem_write   <= 1'b0;
                pmem_wmask   <= '0;
            end
            if (grant_d) begin
                serve_d      <= 1'b1;
                pmem_address <= {dmem_address[31:2], 2'b00};
                // Saturates at the limit; only grows while imem is actually waiting.
                if (!imem_read)    dstreak <= '0;
                else if (!starved) dstreak <= dstreak + 1'b1;
                if (dmem_write) begin
                    pmem_read  <= 1'b0;
                    pmem_write <= 1'b1;
                    pmem_wmask <= dmem_wmask;
                    pmem_wdata <= dmem_wdata;
                end else begin
                    pmem_read  <= 1'b1;
                    pmem_write <= 1'b0;
                    pmem_wmask <= '0;
                end
            end
            if ((state == IBUSY || state == DBUSY) && pmem_resp) begin
                pmem_read  <= 1'b0;
                pmem_write <= 1'b0;
                if (state == IBUSY)  imem_rdata <= pmem_rdata;
                else if (pmem_read)  dmem_rdata <= pmem_rdata;
            end
            if (state == RESP) begin
                if (serve_d) dmem_resp <= 1'b1;
                else         imem_resp <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations, then random
// traffic checked every cycle against a transaction-level model.
module tb_mem_arbiter;

    localparam int unsigned SL = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_address;
    logic        imem_read;
    logic [31:0] imem_rdata;
    logic        imem_resp;
    logic [31:0] dmem_address;
    logic        dmem_read;
    logic        dmem_write;
    logic [3:0]  dmem_wmask;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;
    logic [31:0] pmem_address;
    logic        pmem_read;
    logic        pmem_write;
    logic [3:0]  pmem_wmask;
    logic [31:0] pmem_wdata;
    logic [31:0] pmem_rdata;
    logic        pmem_resp;

    int n_cmp  = 0;
    int n_fail = 0;
    bit cmp_en   = 1'b0;
    bit auto_mem = 1'b0;
    bit rand_on  = 1'b0;
    int unsigned resp_lag = 0;

    mem_arbiter #(.STARVE_LIMIT(SL)) dut (
        .clk(clk), .rst(rst),
        .imem_address(imem_address), .imem_read(imem_read),
        .imem_rdata(imem_rdata), .imem_resp(imem_resp),
        .dmem_address(dmem_address), .dmem_read(dmem_read), .dmem_write(dmem_write),
        .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
        .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_wmask(pmem_wmask), .pmem_wdata(pmem_wdata),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level reference: one job at a time, each job occupies the port
    // until memory answers, then a response cycle, then the port pulses *_resp.
    logic        e_rd, e_wr, e_iresp, e_dresp;
    logic [31:0] e_addr, e_wdata, e_irdata, e_drdata;
    logic [3:0]  e_wmask;
    bit          m_busy, m_done, m_d, m_w;
    int unsigned m_streak;

    task automatic model_step();
        bit dreq;
        if (rst) begin
            e_rd = 0; e_wr = 0; e_iresp = 0; e_dresp = 0;
            e_addr = 0; e_wdata = 0; e_irdata = 0; e_drdata = 0; e_wmask = 0;
            m_busy = 0; m_done = 0; m_d = 0; m_w = 0; m_streak = 0;
            return;
        end
        e_iresp = 0;
        e_dresp = 0;
        if (m_done) begin
            if (m_d) e_dresp = 1;
            else     e_iresp = 1;
            m_busy = 0;
            m_done = 0;
        end else if (m_busy) begin
            if (pmem_resp) begin
                if (!m_d)      e_irdata = pmem_rdata;
                else if (!m_w) e_drdata = pmem_rdata;
                e_rd = 0;
                e_wr = 0;
                m_done = 1;
            end
        end else begin
            dreq = dmem_read || dmem_write;
            if (imem_read && (!dreq || m_streak == SL)) begin
                m_busy = 1; m_d = 0; m_w = 0;
                e_rd = 1; e_wr = 0; e_wmask = 0;
                e_addr = imem_address & 32'hFFFF_FFFC;
                m_streak = 0;
            end else if (dreq) begin
                m_busy = 1; m_d = 1; m_w = dmem_write;
                e_rd = !dmem_write; e_wr = dmem_write;
                e_addr = dmem_address & 32'hFFFF_FFFC;
                if (dmem_write) begin
                    e_wmask = dmem_wmask;
                    e_wdata = dmem_wdata;
                end else begin
                    e_wmask = 0;
                end
                m_streak = imem_read ? ((m_streak < SL) ? m_streak + 1 : SL) : 0;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            chk("pmem_read",  32'(pmem_read),  32'(e_rd));
            chk("pmem_write", 32'(pmem_write), 32'(e_wr));
            if (e_rd || e_wr) begin
                chk("pmem_address", pmem_address, e_addr);
                chk("pmem_wmask",   32'(pmem_wmask), 32'(e_wmask));
            end
            if (e_wr) chk("pmem_wdata", pmem_wdata, e_wdata);
            chk("imem_rdata", imem_rdata, e_irdata);
            chk("dmem_rdata", dmem_rdata, e_drdata);
            chk("imem_resp",  32'(imem_resp), 32'(e_iresp));
            chk("dmem_resp",  32'(dmem_resp), 32'(e_dresp));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance to the next falling edge, then play memory and (optionally) random masters.
    task automatic tick();
        int unsigned kind;
        @(negedge clk);
        if (auto_mem) begin
            if ((pmem_read || pmem_write) && !pmem_resp && $urandom_range(0, resp_lag) == 0) begin
                pmem_resp  = 1'b1;
                pmem_rdata = $urandom;
            end else if (rand_on && !(pmem_read || pmem_write) && $urandom_range(0, 7) == 0) begin
                pmem_resp  = 1'b1;
                pmem_rdata = $urandom;
            end else begin
                pmem_resp = 1'b0;
            end
        end
        if (rand_on) begin
            if (imem_resp) begin
                imem_read    = 1'($urandom_range(0, 1));
                imem_address = $urandom;
            end else if (!imem_read) begin
                if ($urandom_range(0, 2) == 0) begin
                    imem_read    = 1'b1;
                    imem_address = $urandom;
                end
            end else if ($urandom_range(0, 31) == 0) begin
                imem_read = 1'b0;
            end
            if (dmem_resp || (!dmem_read && !dmem_write)) begin
                if (dmem_resp || $urandom_range(0, 2) == 0) begin
                    kind         = $urandom_range(0, 4);
                    dmem_read    = (kind == 0 || kind == 1 || kind == 3);
                    dmem_write   = (kind == 2 || kind == 3);
                    dmem_address = $urandom;
                    dmem_wmask   = 4'($urandom);
                    dmem_wdata   = $urandom;
                end
            end else if ($urandom_range(0, 31) == 0) begin
                dmem_read  = 1'b0;
                dmem_write = 1'b0;
            end
            rst = ($urandom_range(0, 299) == 0);
        end
    endtask

    bit [9:0] exp_order = 10'b0111101111;
    bit [9:0] got_d;
    int       ng;
    bit       prev_rd;

    initial begin
        rst = 1'b1;
        imem_address = '0; imem_read = 1'b0;
        dmem_address = '0; dmem_read = 1'b0; dmem_write = 1'b0;
        dmem_wmask = '0; dmem_wdata = '0;
        pmem_rdata = '0; pmem_resp = 1'b0;
        tick();
        cmp_en = 1'b1;
        tick();
        chk("rst_pmem_read",  32'(pmem_read), 32'h0);
        chk("rst_pmem_write", 32'(pmem_write), 32'h0);
        chk("rst_pmem_addr",  pmem_address, 32'h0);
        chk("rst_rdata",      imem_rdata | dmem_rdata, 32'h0);
        chk("rst_resp",       32'({imem_resp, dmem_resp}), 32'h0);
        rst = 1'b0;

        // single fetch, memory answers in the second busy cycle
        imem_read = 1'b1; imem_address = 32'h6000_0006;
        tick();
        chk("fetch_pmem_read", 32'(pmem_read), 32'h1);
        chk("fetch_pmem_addr", pmem_address, 32'h6000_0004);
        tick();
        chk("fetch_hold", 32'(pmem_read), 32'h1);
        pmem_resp = 1'b1; pmem_rdata = 32'h0050_0093;
        tick();
        pmem_resp = 1'b0;
        chk("fetch_read_drop", 32'(pmem_read), 32'h0);
        chk("fetch_rdata", imem_rdata, 32'h0050_0093);
        chk("fetch_resp_early", 32'(imem_resp), 32'h0);
        tick();
        chk("fetch_imem_resp", 32'(imem_resp), 32'h1);
        chk("fetch_dmem_resp", 32'(dmem_resp), 32'h0);
        imem_read = 1'b0;
        tick();
        chk("fetch_resp_pulse", 32'(imem_resp), 32'h0);
        chk("fetch_no_dup", 32'(pmem_read), 32'h0);

        // store
        dmem_write = 1'b1; dmem_address = 32'h100; dmem_wmask = 4'b0011; dmem_wdata = 32'hDEAD_BEEF;
        tick();
        chk("store_write", 32'(pmem_write), 32'h1);
        chk("store_no_read", 32'(pmem_read), 32'h0);
        tick();
        chk("store_wmask", 32'(pmem_wmask), 32'h3);
        chk("store_wdata", pmem_wdata, 32'hDEAD_BEEF);
        chk("store_addr", pmem_address, 32'h100);
        pmem_resp = 1'b1; pmem_rdata = 32'h1357_9BDF;
        tick();
        pmem_resp = 1'b0;
        chk("store_write_drop", 32'(pmem_write), 32'h0);
        tick();
        chk("store_dmem_resp", 32'(dmem_resp), 32'h1);
        chk("store_rdata_kept", dmem_rdata, 32'h0);
        dmem_write = 1'b0;
        tick();

        // read and write together is a write
        dmem_read = 1'b1; dmem_write = 1'b1; dmem_address = 32'h206;
        dmem_wmask = 4'hF; dmem_wdata = 32'h1234_5678;
        tick();
        chk("rw_write", 32'(pmem_write), 32'h1);
        chk("rw_no_read", 32'(pmem_read), 32'h0);
        chk("rw_addr", pmem_address, 32'h204);
        pmem_resp = 1'b1; pmem_rdata = 32'hAAAA_AAAA;
        tick();
        pmem_resp = 1'b0;
        tick();
        chk("rw_dmem_resp", 32'(dmem_resp), 32'h1);
        chk("rw_rdata_kept", dmem_rdata, 32'h0);
        dmem_read = 1'b0; dmem_write = 1'b0;
        tick();

        // spurious response while idle
        pmem_resp = 1'b1; pmem_rdata = 32'hFFFF_FFFF;
        tick();
        pmem_resp = 1'b0;
        chk("spur_irdata", imem_rdata, 32'h0050_0093);
        chk("spur_drdata", dmem_rdata, 32'h0);
        chk("spur_req", 32'({pmem_read, pmem_write}), 32'h0);
        tick();
        chk("spur_resp", 32'({imem_resp, dmem_resp}), 32'h0);

        // reset in the middle of a data read, late memory answer
        dmem_read = 1'b1; dmem_address = 32'h300;
        tick();
        chk("abort_busy", 32'(pmem_read), 32'h1);
        rst = 1'b1;
        tick();
        chk("abort_read_low", 32'(pmem_read), 32'h0);
        rst = 1'b0; dmem_read = 1'b0;
        tick();
        pmem_resp = 1'b1; pmem_rdata = 32'h5555_5555;
        tick();
        pmem_resp = 1'b0;
        chk("abort_read_stays_low", 32'(pmem_read), 32'h0);
        chk("abort_drdata", dmem_rdata, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("abort_no_dresp", 32'(dmem_resp), 32'h0);
        end

        // contention with both ports held high
        auto_mem = 1'b1; resp_lag = 0;
        imem_read = 1'b1; imem_address = 32'h1000;
        dmem_read = 1'b1; dmem_address = 32'h2000;
        ng = 0; prev_rd = 1'b0; got_d = '0;
        for (int c = 0; c < 80 && ng < 10; c++) begin
            tick();
            if (pmem_read && !prev_rd) begin
                got_d[ng] = (pmem_address == 32'h2000);
                ng++;
            end
            prev_rd = pmem_read;
        end
        chk("contend_grants", 32'(ng), 32'd10);
        for (int i = 0; i < 10; i++) chk("contend_order", 32'(got_d[i]), 32'(exp_order[i]));
        imem_read = 1'b0; dmem_read = 1'b0;
        repeat (6) tick();

        // random traffic
        resp_lag = 2;
        rand_on = 1'b1;
        repeat (3000) tick();
        rand_on = 1'b0;
        rst = 1'b0;
        imem_read = 1'b0; dmem_read = 1'b0; dmem_write = 1'b0;
        repeat (10) tick();
        auto_mem = 1'b0;
        pmem_resp = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: the maximum number of consecutive dmem grants while imem is waiting.
REQ-002 SHALL have port clk, input, 1 bit: clock; all state SHALL update on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-004 SHALL have imem_address, input, 32 bits: instruction fetch address.
REQ-005 SHALL have imem_read, input, 1 bit: fetch request, held high until imem_resp.
REQ-006 SHALL have imem_rdata, output, 32 bits: fetch data.
REQ-007 SHALL have imem_resp, output, 1 bit: one-cycle fetch completion pulse.
REQ-008 SHALL have dmem_address, input, 32 bits: data address.
REQ-009 SHALL have dmem_read and dmem_write, inputs, 1 bit each: data requests, held until dmem_resp.
REQ-010 SHALL have dmem_wmask, input, 4 bits: byte enables for stores.
REQ-011 SHALL have dmem_wdata, input, 32 bits: store data.
REQ-012 SHALL have dmem_rdata, output, 32 bits: load data.
REQ-013 SHALL have dmem_resp, output, 1 bit: one-cycle data completion pulse.
REQ-014 SHALL have pmem_address, output, 32 bits: physical address, word aligned.
REQ-015 SHALL have pmem_read and pmem_write, outputs, 1 bit each: physical memory requests.
REQ-016 SHALL have pmem_wmask, output, 4 bits: physical byte enables.
REQ-017 SHALL have pmem_wdata, output, 32 bits: physical store data.
REQ-018 SHALL have pmem_rdata, input, 32 bits: physical read data.
REQ-019 SHALL have pmem_resp, input, 1 bit: physical completion, valid for one cycle.

Function
REQ-020 SHALL implement states IDLE, IBUSY, DBUSY and RESP.
- All pmem_* outputs SHALL be registered.
- imem_resp and dmem_resp SHALL be registered.
REQ-021 In IDLE, SHALL sample requests and grant at most one.
- Grant in cycle N: pmem request asserted in cycle N+1.
- State moves to IBUSY or DBUSY.
REQ-022 At grant, SHALL latch the following, held constant until pmem_resp:
- pmem_address = {addr[31:2], 2'b00};
- for dmem writes, also wmask and wdata.
- For reads, pmem_wmask SHALL be 4'b0000.
REQ-023 A dmem request with both dmem_read and dmem_write high SHALL be serviced as a write only.
REQ-024 SHALL resolve simultaneous imem and dmem requests as follows:
- dmem wins, unless dstreak == STARVE_LIMIT;
- in that case imem wins.
REQ-025 dstreak (a saturating counter, width clog2(STARVE_LIMIT+1)) SHALL update at each grant:
- incremented on a dmem grant with imem_read high;
- cleared on an imem grant;
- cleared on a dmem grant with imem_read low.
REQ-026 In IBUSY or DBUSY, SHALL hold the pmem request until pmem_resp.
- On pmem_resp, SHALL deassert pmem_read and pmem_write in the next cycle.
- On pmem_resp, SHALL capture pmem_rdata into imem_rdata or dmem_rdata (reads only).
- On pmem_resp, SHALL enter RESP.
REQ-027 In RESP, SHALL assert exactly one of imem_resp or dmem_resp for exactly one cycle.
- No new grant SHALL be made in RESP.
- The next state SHALL be IDLE.
REQ-028 Minimum latency: request in IDLE at cycle N, pmem_resp at N+1 → *_resp high at cycle N+3.
REQ-029 imem_rdata and dmem_rdata SHALL hold their last captured values until the next read completion of the same port.
- dmem_rdata SHALL be unchanged by writes.
REQ-030 pmem_resp received in IDLE or RESP SHALL be ignored, with no state or data change.
REQ-031 A request deasserted before grant SHALL NOT be serviced.
- Requests SHALL NOT be queued.
REQ-032 Only one pmem transaction SHALL be outstanding at any time.
- pmem_read and pmem_write SHALL never be high simultaneously.

Reset
REQ-033 On rst, SHALL enter IDLE and clear dstreak.
REQ-034 On rst, SHALL clear pmem_read, pmem_write, pmem_wmask, pmem_address, pmem_wdata, imem_resp and dmem_resp to 0.
REQ-035 On rst, SHALL clear imem_rdata and dmem_rdata to 32'h0.
REQ-036 rst during IBUSY or DBUSY SHALL abort the transaction.
- The pmem request SHALL be low in the cycle after rst.
- A late pmem_resp SHALL be ignored and no *_resp SHALL be issued.

Verification
REQ-037 Single fetch: imem_read=1, imem_address=0x60000006, pmem_resp at 2nd busy cycle with pmem_rdata=0x00500093 → pmem_address=0x60000004, imem_rdata=0x00500093, imem_resp one-cycle pulse, dmem_resp=0.
REQ-038 Store: dmem_write=1, dmem_address=0x100, wmask=4'b0011, wdata=0xDEADBEEF → pmem_write=1, pmem_wmask=4'b0011, pmem_wdata=0xDEADBEEF until pmem_resp, then dmem_resp pulse; dmem_rdata unchanged.
REQ-039 Contention: imem_read and dmem_read held high continuously with STARVE_LIMIT=4 → grant order D,D,D,D,I,D,D,D,D,I; no duplicate service after any resp.
REQ-040 Read+write together: dmem_read=dmem_write=1 → only pmem_write asserted.
REQ-041 Reset mid-op: rst asserted in DBUSY, pmem_resp arrives 1 cycle after rst release → pmem_read=0, dmem_resp never asserted, state IDLE.
REQ-042 Spurious response: pmem_resp pulsed in IDLE with no requests → all outputs unchanged.
